segment_write_queue: RTL and testbench

- Buffers segment-register write requests from the writeback stage and sends them to the segment register file, one write per cycle.
- Tracks which segments have writes still outstanding, so decode/address-generation can stall on a stale segment.
- Sits directly upstream of the segment register file and drives its write_select / write_data / write_enable port.

---
 rtl/segment_write_queue_pkg.sv | 26 ++
 rtl/segment_pending_scoreboard.sv | 69 ++++++
 rtl/segment_write_queue.sv | 154 +++++++++++++++
 tb/tb_segment_write_queue.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/segment_write_queue_pkg.sv
// -----------------------------------------------------------------------------
// segment_write_queue_pkg
//
// Shared definitions for the segment write queue and its pending scoreboard.
// It provides the segment index encoding, the default widths, and a legality
// helper for the segment index.
// -----------------------------------------------------------------------------
package segment_write_queue_pkg;

    localparam int NUM_SEG = 6;
    localparam int SEG_W   = 3;
    localparam int DATA_W  = 16;

    localparam logic [SEG_W-1:0] SEG_ES = 3'd0;
    localparam logic [SEG_W-1:0] SEG_CS = 3'd1;
    localparam logic [SEG_W-1:0] SEG_SS = 3'd2;
    localparam logic [SEG_W-1:0] SEG_DS = 3'd3;
    localparam logic [SEG_W-1:0] SEG_FS = 3'd4;
    localparam logic [SEG_W-1:0] SEG_GS = 3'd5;

    // Indices 6 and 7 do not name a segment register.
    function automatic logic is_legal_seg(input logic [SEG_W-1:0] seg);
        return int'(seg) < NUM_SEG;
    endfunction

endpackage

// File: rtl/segment_pending_scoreboard.sv
// -----------------------------------------------------------------------------
// segment_pending_scoreboard
//
// Holds one occupancy counter per segment. A counter counts the writes to its
// segment that are queued or being presented to the register file. pending[k]
// is high while counter k is non-zero.
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   push_en   a legal write is entering the queue
//   push_seg  segment of the write that enters
//   pop_en    the head write is retiring this cycle
//   pop_seg   segment of the head write
//   clear     synchronous clear of every counter (flush)
//   pending   per-segment outstanding-write flags
// -----------------------------------------------------------------------------
module segment_pending_scoreboard
    import segment_write_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push_en,
    input  logic [SEG_W-1:0]   push_seg,
    input  logic               pop_en,
    input  logic [SEG_W-1:0]   pop_seg,
    input  logic               clear,
    output logic [NUM_SEG-1:0] pending
);

    // A counter must be able to hold DEPTH, so it is one bit wider than a pointer.
    localparam int CTR_W = $clog2(DEPTH) + 1;

    logic [CTR_W-1:0]   ctr [NUM_SEG];
    logic [NUM_SEG-1:0] inc;
    logic [NUM_SEG-1:0] dec;

    // NOTE: every signal written in an always_comb gets a value on every path
    // (here the loop covers all bits); a missed path would infer a latch.
    always_comb begin
        for (int k = 0; k < NUM_SEG; k++) begin
            inc[k]     = push_en && (push_seg == SEG_W'(k));
            dec[k]     = pop_en  && (pop_seg  == SEG_W'(k));
            pending[k] = (ctr[k] != '0);
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples values from before the edge regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_SEG; k++) ctr[k] <= '0;
        end else if (clear) begin
            for (int k = 0; k < NUM_SEG; k++) ctr[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_SEG; k++) begin
                // A push and a pop of the same segment cancel out.
                if (inc[k] && !dec[k]) begin
                    ctr[k] <= ctr[k] + 1'b1;
                end else if (dec[k] && !inc[k]) begin
                    ctr[k] <= ctr[k] - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/segment_write_queue.sv
// -----------------------------------------------------------------------------
// segment_write_queue
//
// Buffers segment-register writes from writeback and presents them, one per
// cycle, to the segment register file. The queue is strict FIFO. The head
// entry retires on every cycle that write_enable is high, and the register file
// never applies backpressure. A scoreboard reports which segments still have
// writes outstanding, so decode can stall on a stale segment.
//
// Optional build macro: SEG_WRITE_QUEUE_BYPASS_EN
//   When it is defined, a legal write that arrives while the queue is empty goes
//   straight to the register file in the same cycle. That write is not queued
//   and does not set pending. When it is undefined, every output comes from
//   flops.
//
// Ports:
//   clk           system clock
//   reset         asynchronous active-low reset
//   in_valid      writeback offers a write
//   in_ready      queue can accept (not full)
//   in_seg        target segment index (6 and 7 are illegal)
//   in_data       selector value
//   flush         synchronous discard of every queued write
//   write_select  register file: head segment index
//   write_data    register file: head data
//   write_enable  register file: head valid
//   pending       bit k high while a write to segment k is outstanding
//   count         queue occupancy
//   illegal_seg   one-cycle pulse after an illegal index was dropped
// -----------------------------------------------------------------------------
module segment_write_queue
    import segment_write_queue_pkg::NUM_SEG, segment_write_queue_pkg::is_legal_seg;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16,
    parameter int SEG_W  = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SEG_W-1:0]       in_seg,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   flush,
    output logic [SEG_W-1:0]       write_select,
    output logic [DATA_W-1:0]      write_data,
    output logic                   write_enable,
    output logic [NUM_SEG-1:0]     pending,
    output logic [$clog2(DEPTH):0] count,
    output logic                   illegal_seg
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [SEG_W-1:0]  seg_mem  [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  occ;

    logic              empty;
    logic              full;
    logic              accept;
    logic              legal;
    logic              bypass;
    logic              push;
    logic              pop;
    logic [SEG_W-1:0]  head_seg;
    logic [DATA_W-1:0] head_data;

    assign empty    = (occ == '0);
    assign full     = (occ == CNT_W'(DEPTH));
    assign in_ready = !full;
    assign count    = occ;

    // Flush has priority over a request offered in the same cycle.
    assign accept = in_valid && in_ready && !flush;
    assign legal  = is_legal_seg(in_seg);

`ifdef SEG_WRITE_QUEUE_BYPASS_EN
    assign bypass = accept && legal && empty;
`else
    assign bypass = 1'b0;
`endif

    assign push = accept && legal && !bypass;
    // The head always retires when it is valid. During a flush the clear wins.
    assign pop  = !empty;

    // The head is forced to zero when empty, so stale storage never reaches
    // the register file port.
    assign head_seg  = empty ? '0 : seg_mem[rd_ptr];
    assign head_data = empty ? '0 : data_mem[rd_ptr];

`ifdef SEG_WRITE_QUEUE_BYPASS_EN
    assign write_enable = !empty || bypass;
    assign write_select = bypass ? in_seg  : head_seg;
    assign write_data   = bypass ? in_data : head_data;
`else
    assign write_enable = !empty;
    assign write_select = head_seg;
    assign write_data   = head_data;
`endif

    // NOTE: the storage array has no reset. Only the pointers and the count
    // decide which entries are valid, so entry contents never need a known value.
    always_ff @(posedge clk) begin
        if (push) begin
            seg_mem[wr_ptr]  <= in_seg;
            data_mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occ         <= '0;
            illegal_seg <= 1'b0;
        end else begin
            // An illegal index completes its handshake but is never stored.
            illegal_seg <= accept && !legal;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                occ    <= '0;
            end else begin
                // DEPTH is a power of two, so the pointers wrap on overflow.
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   occ <= occ + 1'b1;
                    2'b01:   occ <= occ - 1'b1;
                    default: occ <= occ;
                endcase
            end
        end
    end

    segment_pending_scoreboard #(
        .DEPTH (DEPTH)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (reset),
        .push_en  (push),
        .push_seg (in_seg),
        .pop_en   (pop),
        .pop_seg  (head_seg),
        .clear    (flush),
        .pending  (pending)
    );

endmodule

// File: tb/tb_segment_write_queue.sv
// -----------------------------------------------------------------------------
// tb_segment_write_queue
//
// Directed bench for segment_write_queue in its default build (bypass macro
// undefined). A small register-file model captures each write the DUT presents,
// so retire order and last-write-wins can be checked against hand-computed
// values.
// -----------------------------------------------------------------------------
module tb_segment_write_queue;
    import segment_write_queue_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_seg = '0;
    logic [15:0] in_data = '0;
    logic        flush = 1'b0;
    logic [2:0]  write_select;
    logic [15:0] write_data;
    logic        write_enable;
    logic [5:0]  pending;
    logic [2:0]  count;
    logic        illegal_seg;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] rf [8];
    logic [2:0]  log_seg [$];
    logic [15:0] log_data [$];

    always #5 clk = ~clk;

    segment_write_queue #(.DEPTH(4), .DATA_W(16), .SEG_W(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_seg       (in_seg),
        .in_data      (in_data),
        .flush        (flush),
        .write_select (write_select),
        .write_data   (write_data),
        .write_enable (write_enable),
        .pending      (pending),
        .count        (count),
        .illegal_seg  (illegal_seg)
    );

    // Register-file model: captures whatever the DUT presents at each edge.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) rf[i] <= '0;
        end else if (write_enable) begin
            rf[write_select] <= write_data;
            log_seg.push_back(write_select);
            log_data.push_back(write_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        vectors++; if (write_enable !== 1'b0) begin miscompares++; $display("FAIL reset_we: got %b want 0", write_enable); end
        vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", count); end
        vectors++; if (pending !== 6'b0) begin miscompares++; $display("FAIL reset_pending: got %b want 000000", pending); end
        vectors++; if (write_select !== 3'd0 || write_data !== 16'h0) begin miscompares++; $display("FAIL reset_head: got %0d/%h want 0/0000", write_select, write_data); end
        vectors++; if (illegal_seg !== 1'b0) begin miscompares++; $display("FAIL reset_illegal: got %b want 0", illegal_seg); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", in_ready); end
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single_write();
        int n0;
        n0 = log_seg.size();
        in_valid = 1'b1; in_seg = SEG_DS; in_data = 16'h1234;
        tick();
        in_valid = 1'b0;
        vectors++; if (write_enable !== 1'b1) begin miscompares++; $display("FAIL single_we1: got %b want 1", write_enable); end
        vectors++; if (write_select !== 3'd3 || write_data !== 16'h1234) begin miscompares++; $display("FAIL single_head: got %0d/%h want 3/1234", write_select, write_data); end
        vectors++; if (pending !== 6'b001000) begin miscompares++; $display("FAIL single_pending1: got %b want 001000", pending); end
        vectors++; if (count !== 3'd1) begin miscompares++; $display("FAIL single_count1: got %0d want 1", count); end
        tick();
        vectors++; if (write_enable !== 1'b0) begin miscompares++; $display("FAIL single_we2: got %b want 0", write_enable); end
        vectors++; if (pending !== 6'b0) begin miscompares++; $display("FAIL single_pending2: got %b want 000000", pending); end
        vectors++; if (rf[3] !== 16'h1234) begin miscompares++; $display("FAIL single_rf: got %h want 1234", rf[3]); end
        vectors++; if (log_seg.size() !== n0 + 1) begin miscompares++; $display("FAIL single_nwrites: got %0d want %0d", log_seg.size() - n0, 1); end
    endtask

    // Four back-to-back pushes; each retires one cycle later, so occupancy
    // stays at one and the head tracks the previous request.
    task automatic test_back_to_back();
        logic [2:0]  segs [4] = '{SEG_ES, SEG_CS, SEG_SS, SEG_ES};
        logic [15:0] vals [4] = '{16'h0E01, 16'h0C02, 16'h055A, 16'h0E04};
        logic [5:0]  pend [4] = '{6'b000001, 6'b000010, 6'b000100, 6'b000001};
        int n0;
        n0 = log_seg.size();
        for (int i = 0; i < 4; i++) begin
            vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready%0d: got %b want 1", i, in_ready); end
            in_valid = 1'b1; in_seg = segs[i]; in_data = vals[i];
            tick();
            vectors++; if (write_select !== segs[i] || write_data !== vals[i]) begin miscompares++; $display("FAIL b2b_head%0d: got %0d/%h want %0d/%h", i, write_select, write_data, segs[i], vals[i]); end
            vectors++; if (pending !== pend[i]) begin miscompares++; $display("FAIL b2b_pending%0d: got %b want %b", i, pending, pend[i]); end
            vectors++; if (count !== 3'd1) begin miscompares++; $display("FAIL b2b_count%0d: got %0d want 1", i, count); end
        end
        in_valid = 1'b0;
        tick();
        vectors++; if (write_enable !== 1'b0 || pending !== 6'b0) begin miscompares++; $display("FAIL b2b_drained: got we=%b pend=%b want 0/000000", write_enable, pending); end
        vectors++; if (log_seg.size() !== n0 + 4) begin miscompares++; $display("FAIL b2b_nwrites: got %0d want 4", log_seg.size() - n0); end
        else begin
            for (int i = 0; i < 4; i++) begin
                vectors++; if (log_seg[n0+i] !== segs[i] || log_data[n0+i] !== vals[i]) begin miscompares++; $display("FAIL b2b_order%0d: got %0d/%h want %0d/%h", i, log_seg[n0+i], log_data[n0+i], segs[i], vals[i]); end
            end
        end
        vectors++; if (rf[0] !== 16'h0E04) begin miscompares++; $display("FAIL b2b_lastwins: got %h want 0e04", rf[0]); end
    endtask

    task automatic test_illegal();
        int n0;
        n0 = log_seg.size();
        in_valid = 1'b1; in_seg = 3'd7; in_data = 16'hFFFF;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL illegal_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        vectors++; if (illegal_seg !== 1'b1) begin miscompares++; $display("FAIL illegal_pulse: got %b want 1", illegal_seg); end
        vectors++; if (count !== 3'd0 || write_enable !== 1'b0) begin miscompares++; $display("FAIL illegal_dropped: got cnt=%0d we=%b want 0/0", count, write_enable); end
        vectors++; if (pending !== 6'b0) begin miscompares++; $display("FAIL illegal_pending: got %b want 000000", pending); end
        tick();
        vectors++; if (illegal_seg !== 1'b0) begin miscompares++; $display("FAIL illegal_oneshot: got %b want 0", illegal_seg); end
        vectors++; if (log_seg.size() !== n0) begin miscompares++; $display("FAIL illegal_nwrites: got %0d want 0", log_seg.size() - n0); end
    endtask

    task automatic test_flush();
        in_valid = 1'b1; in_seg = SEG_FS; in_data = 16'h4444;
        tick();
        // Flush together with a new request: the request must be dropped.
        flush = 1'b1; in_seg = SEG_GS; in_data = 16'h5555;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_ready_pre: got %b want 1", in_ready); end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        vectors++; if (count !== 3'd0 || pending !== 6'b0) begin miscompares++; $display("FAIL flush_clear: got cnt=%0d pend=%b want 0/000000", count, pending); end
        vectors++; if (write_enable !== 1'b0) begin miscompares++; $display("FAIL flush_we: got %b want 0", write_enable); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_ready_post: got %b want 1", in_ready); end
        tick();
        vectors++; if (write_enable !== 1'b0 || rf[5] !== 16'h0) begin miscompares++; $display("FAIL flush_dropped: got we=%b rf5=%h want 0/0000", write_enable, rf[5]); end
    endtask

    task automatic test_same_seg_stream();
        logic [15:0] vals [3] = '{16'h000A, 16'h000B, 16'h000C};
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_seg = SEG_DS; in_data = vals[i];
            tick();
            vectors++; if (pending !== 6'b001000) begin miscompares++; $display("FAIL stream_pending%0d: got %b want 001000", i, pending); end
            vectors++; if (dut.u_scoreboard.ctr[3] !== 3'd1) begin miscompares++; $display("FAIL stream_ctr%0d: got %0d want 1", i, dut.u_scoreboard.ctr[3]); end
            vectors++; if (write_data !== vals[i]) begin miscompares++; $display("FAIL stream_head%0d: got %h want %h", i, write_data, vals[i]); end
        end
        in_valid = 1'b0;
        tick();
        vectors++; if (pending !== 6'b0) begin miscompares++; $display("FAIL stream_pending_end: got %b want 000000", pending); end
        vectors++; if (rf[3] !== 16'h000C) begin miscompares++; $display("FAIL stream_rf: got %h want 000c", rf[3]); end
    endtask

    task automatic test_reset_mid();
        int n0;
        n0 = log_seg.size();
        in_valid = 1'b1; in_seg = SEG_CS; in_data = 16'h0055;
        tick();
        in_valid = 1'b0;
        vectors++; if (write_enable !== 1'b1) begin miscompares++; $display("FAIL rstmid_loaded: got %b want 1", write_enable); end
        reset = 1'b0;
        #1;
        vectors++; if (count !== 3'd0 || pending !== 6'b0) begin miscompares++; $display("FAIL rstmid_clear: got cnt=%0d pend=%b want 0/000000", count, pending); end
        vectors++; if (write_enable !== 1'b0 || write_select !== 3'd0) begin miscompares++; $display("FAIL rstmid_head: got we=%b sel=%0d want 0/0", write_enable, write_select); end
        @(negedge clk);
        reset = 1'b1;
        tick();
        vectors++; if (in_ready !== 1'b1 || count !== 3'd0) begin miscompares++; $display("FAIL rstmid_release: got rdy=%b cnt=%0d want 1/0", in_ready, count); end
        vectors++; if (log_seg.size() !== n0) begin miscompares++; $display("FAIL rstmid_lost: got %0d writes want 0", log_seg.size() - n0); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_back_to_back();
        test_illegal();
        test_flush();
        test_same_seg_stream();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
